truth_table_extractor: RTL and testbench
========================================

Name: truth_table_extractor

Overview:
- Sequential characteriser for small combinational gate-level blocks.
- On `start`, it sweeps every input combination of an N-input function under test (FUT) and samples the FUT output `f` for each one.
- It assembles the 2^N-bit truth table, then streams the minterm indices out over a valid/ready handshake.
- It is the inverse of a minterm-expression block: it recovers the minterm list from the gate network. It sits beside the FUT in self-checking labs and benches.

Parameters:
- N_INPUTS, 2, number of FUT inputs; legal range 1..6.
- SETTLE_CYCLES, 2, cycles `dut_in` is held before the sampling cycle; must be >= 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- dut_in  output  N_INPUTS  FUT input vector; bit N_INPUTS-1 is the first FUT input (a), bit 0 is the last (b); vector value = truth-table index.
- dut_f  input  1  FUT output f.
- busy  output  1  high in every state except IDLE.
- table_out  output  2^N_INPUTS  bit i = f sampled with dut_in == i.
- minterm_count  output  N_INPUTS+1  number of ones in `table_out`.
- minterm_valid  output  1  a minterm index is presented.
- minterm_ready  input  1  consumer accepts the minterm when valid & ready.
- minterm_idx  output  N_INPUTS  presented minterm index.
- minterm_last  output  1  presented minterm is the highest set index.
- done  output  1  one-cycle pulse at sweep completion.

Behaviour:
- **Reset (async, rst_n=0)**
  - State = IDLE.
  - dut_in, table_out, minterm_count, minterm_idx all 0.
  - busy, done, minterm_valid, minterm_last all 0.
  - Reset takes effect immediately in any state, including mid-sweep or mid-handshake; no partial results are kept.
- **States:** IDLE, DRIVE, SAMPLE, EMIT, DONE.
- **IDLE**
  - `start`=1 at an edge: idx<=0, dut_in<=0, settle cnt<=0, table_out<=0, minterm_count<=0, go to DRIVE.
  - `start` in any other state is ignored.
- **DRIVE**
  - dut_in = idx, held stable.
  - cnt increments each cycle.
  - When cnt == SETTLE_CYCLES-1, go to SAMPLE.
  - DRIVE therefore lasts exactly SETTLE_CYCLES cycles.
- **SAMPLE** (one cycle)
  - At its closing edge: table_out[idx] <= dut_f, minterm_count += dut_f.
  - If idx == 2^N-1: ptr<=0, go to EMIT.
  - Else: idx+1, cnt<=0, go to DRIVE.
  - idx never wraps; sweep length = 2^N × (SETTLE_CYCLES+1) cycles.
- **EMIT** (one ptr step per cycle)
  - If table_out[ptr]=0: minterm_valid=0, ptr advances next cycle.
  - If table_out[ptr]=1: minterm_valid=1, minterm_idx=ptr, minterm_last = (no set bit above ptr).
    - Hold valid and idx stable until minterm_ready=1.
    - Advance ptr on the accepting edge.
  - ptr == 2^N-1 and consumed or zero: go to DONE.
  - Table all zeros: no valid is ever asserted; minterm_last is never asserted.
  - ready while valid=0 has no effect.
  - valid never drops without acceptance.
- **DONE** (one cycle)
  - done=1, then IDLE.
- **After completion**
  - table_out and minterm_count hold until the next accepted start.
  - dut_in returns to 0 in IDLE.
- **Widths**
  - minterm_count is never truncated; the max 2^N fits in N+1 bits.

Test Plan:
- **Constant-1 FUT** (N=2, SETTLE=2; f=1 for all inputs), ready tied high:
  - busy high 12 cycles of sweep; table_out=4'b1111, minterm_count=3'd4.
  - minterm_idx 0,1,2,3 on consecutive cycles; last only with idx 3; single-cycle done.
- **XOR FUT**:
  - table_out=4'b0110, count=2; minterms 1 then 2; last on 2.
  - EMIT total 4 cycles.
- **Constant-0 FUT**:
  - table_out=0, count=0; minterm_valid never asserted; done pulses after 4 EMIT cycles.
- **Backpressure** (XOR FUT, ready low 5 cycles while idx=1 presented):
  - valid/idx/last stay 1/1/0 throughout; idx 2 appears only after the accepting edge.
- **Reset and start guards**:
  - rst_n low mid-DRIVE (idx=2) and again mid-EMIT: all outputs 0 asynchronously, IDLE.
  - A new start gives a full, correct sweep.
  - start pulsed while busy is ignored; no restart, results unchanged.
- **dut_in sequencing check**:
  - Sequence is 0,1,2,3, each held exactly SETTLE_CYCLES+1 cycles before its sample edge.

Source files
------------

// File: rtl/truth_table_extractor.sv
// Sweeps all input combinations of a small combinational block, captures its truth table,
// then streams the set minterm indices out over a valid/ready handshake.
module truth_table_extractor #(
    parameter int N_INPUTS      = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic [N_INPUTS-1:0]        dut_in,
    input  logic                       dut_f,
    output logic                       busy,
    output logic [(1<<N_INPUTS)-1:0]   table_out,
    output logic [N_INPUTS:0]          minterm_count,
    output logic                       minterm_valid,
    input  logic                       minterm_ready,
    output logic [N_INPUTS-1:0]        minterm_idx,
    output logic                       minterm_last,
    output logic                       done
);

    localparam int TW = 1 << N_INPUTS;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_EMIT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [N_INPUTS-1:0] idx_q, idx_d;
    logic [N_INPUTS-1:0] ptr_q, ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [TW-1:0]       table_q, table_d;
    logic [N_INPUTS:0]   count_q, count_d;
    logic                above_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            table_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            table_q <= table_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        table_d = table_q;
        count_d = count_q;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    table_d = '0;
                    count_d = '0;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SAMPLE: begin
                table_d[idx_q] = dut_f;
                count_d        = count_q + (N_INPUTS + 1)'(dut_f);
                if (idx_q == '1) begin
                    ptr_d   = '0;
                    state_d = S_EMIT;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    cnt_d   = '0;
                    state_d = S_DRIVE;
                end
            end
            S_EMIT: begin
                // Zero entries are skipped in one cycle; set entries wait for the consumer.
                if (!table_q[ptr_q] || minterm_ready) begin
                    if (ptr_q == '1) begin
                        state_d = S_DONE;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        above_set = 1'b0;
        for (int i = 0; i < TW; i++) begin
            if (table_q[i] && (i > int'(ptr_q))) above_set = 1'b1;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign dut_in        = (state_q == S_DRIVE || state_q == S_SAMPLE) ? idx_q : '0;
    assign table_out     = table_q;
    assign minterm_count = count_q;
    assign minterm_valid = (state_q == S_EMIT) && table_q[ptr_q];
    assign minterm_idx   = minterm_valid ? ptr_q : '0;
    assign minterm_last  = minterm_valid && !above_set;

endmodule

// File: tb/tb_truth_table_extractor.sv
// Self-checking bench: a table-driven FUT is swept and the extractor's capture and
// minterm stream are compared against a list-based reference model.
module tb_truth_table_extractor;

    localparam int N  = 2;
    localparam int S  = 2;
    localparam int TW = 1 << N;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [N-1:0]   dut_in;
    logic           dut_f;
    logic           busy;
    logic [TW-1:0]  table_out;
    logic [N:0]     minterm_count;
    logic           minterm_valid;
    logic           minterm_ready = 1'b0;
    logic [N-1:0]   minterm_idx;
    logic           minterm_last;
    logic           done;

    logic [TW-1:0]  fut_tt = '0;
    int             n_asrt = 0;
    int             n_fail = 0;

    assign dut_f = fut_tt[dut_in];

    always #5 clk = ~clk;

    truth_table_extractor #(.N_INPUTS(N), .SETTLE_CYCLES(S)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_in(dut_in), .dut_f(dut_f),
        .busy(busy), .table_out(table_out), .minterm_count(minterm_count),
        .minterm_valid(minterm_valid), .minterm_ready(minterm_ready),
        .minterm_idx(minterm_idx), .minterm_last(minterm_last), .done(done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_valid"}, minterm_valid, 0);
        chk({tag, "_last"},  minterm_last, 0);
        chk({tag, "_idx"},   minterm_idx, 0);
        chk({tag, "_dutin"}, dut_in, 0);
        chk({tag, "_table"}, table_out, 0);
        chk({tag, "_count"}, minterm_count, 0);
    endtask

    // mode: 0 = ready high, 1 = random ready, 2 = ready low for the first 5 presented cycles
    task automatic run_sweep(input logic [TW-1:0] tt, input int mode, input bit poke_start);
        int mins[$];
        int ptr;
        int cycles;
        int shown;
        bit rdy;
        bit exp_valid;
        mins = {};
        for (int i = 0; i < TW; i++) if (tt[i]) mins.push_back(i);
        fut_tt = tt;

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int step = 0; step < TW * (S + 1); step++) begin
            if (step > 0) @(negedge clk);
            if (poke_start) start = (step == 5);
            chk("sweep_dutin", dut_in, step / (S + 1));
            chk("sweep_busy", busy, 1);
            chk("sweep_valid", minterm_valid, 0);
        end
        start = 1'b0;

        ptr = 0; cycles = 0; shown = 0;
        while (ptr < TW && cycles < 100) begin
            @(negedge clk);
            cycles++;
            exp_valid = tt[ptr];
            chk("emit_busy", busy, 1);
            chk("emit_done", done, 0);
            chk("emit_valid", minterm_valid, exp_valid);
            if (exp_valid) begin
                chk("emit_idx", minterm_idx, ptr);
                chk("emit_last", minterm_last, ptr == mins[$]);
            end else begin
                chk("emit_last_idle", minterm_last, 0);
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = (shown >= 5);
            endcase
            if (poke_start && cycles == 1) start = 1'b1;
            else start = 1'b0;
            minterm_ready = rdy;
            if (exp_valid) shown++;
            if (!exp_valid || rdy) ptr++;
        end
        start = 1'b0;

        @(negedge clk);
        minterm_ready = 1'b0;
        chk("done_pulse", done, 1);
        chk("done_valid", minterm_valid, 0);
        chk("done_table", table_out, tt);
        chk("done_count", minterm_count, mins.size());
        @(negedge clk);
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
        chk("post_dutin", dut_in, 0);
        chk("post_table", table_out, tt);
        chk("post_count", minterm_count, mins.size());
    endtask

    initial begin
        logic [TW-1:0] rtt;
        int waited;

        #1 chk_all_zero("reset");
        @(negedge clk); rst_n = 1'b1;

        run_sweep(4'b1111, 0, 1'b0);   // constant-1
        run_sweep(4'b0110, 0, 1'b0);   // XOR
        run_sweep(4'b0000, 0, 1'b0);   // constant-0
        run_sweep(4'b0110, 2, 1'b0);   // XOR with backpressure on idx 1
        run_sweep(4'b1001, 0, 1'b1);   // start pokes while busy

        // reset mid-DRIVE with idx 2 on the FUT
        fut_tt = 4'b1111;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        waited = 0;
        while (dut_in != 2 && waited < 50) begin @(negedge clk); waited++; end
        chk("wait_idx2", dut_in, 2);
        rst_n = 1'b0;
        #1 chk_all_zero("rst_drive");
        @(negedge clk); rst_n = 1'b1;
        run_sweep(4'b0110, 1, 1'b0);

        // reset mid-EMIT while a minterm is held
        fut_tt = 4'b1111;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (TW * (S + 1) + 1) @(negedge clk);
        chk("hold_valid", minterm_valid, 1);
        rst_n = 1'b0;
        #1 chk_all_zero("rst_emit");
        @(negedge clk); rst_n = 1'b1;

        for (int k = 0; k < 6; k++) begin
            rtt = TW'($urandom);
            run_sweep(rtt, (k % 2 == 0) ? 1 : 0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
